ws2812b_sched: RTL

WS2812B_SCHED -- requirements
Module: ws2812b_sched

---
 rtl/ws2812b_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ws2812b_sched.sv
// ============================================================================
// Module  : ws2812b_sched
// Brief   : Frame-timed chase-pattern scheduler for a WS2812B strip with host
//           write arbitration. Optional trail LED: define WS2812B_SCHED_TRAIL_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812b_sched #(
    parameter int          NB_LEDS     = 5,
    parameter int          FCLK        = 100,
    parameter int          FRAME_US    = 20000,
    parameter logic [23:0] CHASE_COLOR = 24'hFF0000,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       host_req,
    input  logic [$clog2(NB_LEDS)-1:0] host_led,
    input  logic [23:0]                host_color,
    output logic                       host_ack,
    output logic [23:0]                color,
    output logic [$clog2(NB_LEDS)-1:0] nb_led,
    output logic                       write,
    output logic                       frame_done,
    output logic                       overrun
);

    localparam int                c_iw        = $clog2(NB_LEDS);
    localparam int                c_frame_cyc = FRAME_US * FCLK;
    localparam int                c_cw        = (c_frame_cyc > 1) ? $clog2(c_frame_cyc) : 1;
    localparam logic [c_cw-1:0]   c_cnt_last  = c_cw'(c_frame_cyc - 1);
    localparam logic [c_iw-1:0]   c_led_last  = c_iw'(NB_LEDS - 1);
    localparam logic [c_iw:0]     c_nb        = (c_iw + 1)'(NB_LEDS);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_sweep = 1'b1;

    logic [c_cw-1:0] r_cnt;
    logic [0:0]      r_state;
    logic [c_iw-1:0] r_idx;
    logic [c_iw-1:0] r_head;
    logic            w_tick;
    logic            w_grant;
    logic            w_host_valid;
    logic [23:0]     w_sweep_color;

    assign w_tick       = en && (r_cnt == c_cnt_last);
    // host_ack high means a grant was just issued; blocking here avoids a double write
    assign w_grant      = host_req && !host_ack;
    assign w_host_valid = ({1'b0, host_led} < c_nb);

`ifdef WS2812B_SCHED_TRAIL_EN
    localparam logic [23:0] c_trail_color = (CHASE_COLOR >> 1) & 24'h7F7F7F;
    logic [c_iw-1:0] w_trail_idx;

    assign w_trail_idx = (r_head == '0) ? c_led_last : r_head - 1'b1;

    always_comb begin
        w_sweep_color = BG_COLOR;
        if (r_idx == w_trail_idx) begin
            w_sweep_color = c_trail_color;
        end
        if (r_idx == r_head) begin
            w_sweep_color = CHASE_COLOR;
        end
    end
`else
    always_comb begin
        w_sweep_color = BG_COLOR;
        if (r_idx == r_head) begin
            w_sweep_color = CHASE_COLOR;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_idx      <= '0;
            r_head     <= '0;
            write      <= 1'b0;
            color      <= '0;
            nb_led     <= '0;
            host_ack   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            write      <= 1'b0;
            host_ack   <= 1'b0;
            frame_done <= 1'b0;

            if (w_tick && (r_state == c_sweep)) begin
                overrun <= 1'b1;
            end

            // Out-of-range host targets are acknowledged but never reach the strip
            if (w_grant) begin
                host_ack <= 1'b1;
                if (w_host_valid) begin
                    write  <= 1'b1;
                    nb_led <= host_led;
                    color  <= host_color;
                end
            end

            case (r_state)
                c_idle: begin
                    if (w_tick) begin
                        r_state <= c_sweep;
                        r_idx   <= '0;
                    end
                end
                c_sweep: begin
                    if (!w_grant) begin
                        write  <= 1'b1;
                        nb_led <= r_idx;
                        color  <= w_sweep_color;
                        if (r_idx == c_led_last) begin
                            r_state    <= c_idle;
                            r_idx      <= '0;
                            frame_done <= 1'b1;
                            r_head     <= (r_head == c_led_last) ? '0 : r_head + 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
